// File: rtl/decode_pipe_if.sv
// Decode-stage bus: fetch/write-back inputs and decoded outputs towards execute.
// master drives instructions and write-backs; slave is the decode stage.
interface decode_pipe_if #(
  parameter int unsigned AWIDTH  = 5,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned IWIDTH  = 32,
  parameter int unsigned PCWIDTH = 32
);
  logic                d_i_ce;
  logic                d_i_stall;
  logic                d_i_flush;
  logic [IWIDTH-1:0]   d_i_instr;
  logic [PCWIDTH-1:0]  d_i_pc;
  logic                d_i_wr_en;
  logic [AWIDTH-1:0]   d_i_wr_addr;
  logic [DWIDTH-1:0]   d_i_wr_data;

  logic                d_o_ce;
  logic [5:0]          d_o_opcode;
  logic [5:0]          d_o_funct;
  logic [4:0]          d_o_shamt;
  logic [AWIDTH-1:0]   d_o_addr_rs;
  logic [AWIDTH-1:0]   d_o_addr_rt;
  logic [AWIDTH-1:0]   d_o_addr_rd;
  logic [DWIDTH-1:0]   d_o_data_rs;
  logic [DWIDTH-1:0]   d_o_data_rt;
  logic [DWIDTH-1:0]   d_o_imm;
  logic [25:0]         d_o_jaddr;
  logic [PCWIDTH-1:0]  d_o_pc;
  logic                d_o_wr_reg;
  logic [1:0]          d_o_class;

  modport master (
    output d_i_ce, d_i_stall, d_i_flush, d_i_instr, d_i_pc,
    output d_i_wr_en, d_i_wr_addr, d_i_wr_data,
    input  d_o_ce, d_o_opcode, d_o_funct, d_o_shamt, d_o_addr_rs, d_o_addr_rt, d_o_addr_rd,
    input  d_o_data_rs, d_o_data_rt, d_o_imm, d_o_jaddr, d_o_pc, d_o_wr_reg, d_o_class
  );

  modport slave (
    input  d_i_ce, d_i_stall, d_i_flush, d_i_instr, d_i_pc,
    input  d_i_wr_en, d_i_wr_addr, d_i_wr_data,
    output d_o_ce, d_o_opcode, d_o_funct, d_o_shamt, d_o_addr_rs, d_o_addr_rt, d_o_addr_rd,
    output d_o_data_rs, d_o_data_rt, d_o_imm, d_o_jaddr, d_o_pc, d_o_wr_reg, d_o_class
  );
endinterface

// File: rtl/decode_pipe.sv
// Registered MIPS decode stage with integrated register file, write-back bypass,
// stall/flush handling, immediate extension and instruction classification.
module decode_pipe #(
  parameter int unsigned AWIDTH  = 5,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned IWIDTH  = 32,
  parameter int unsigned PCWIDTH = 32
) (
  input logic          d_clk,
  input logic          d_rst,
  decode_pipe_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0]  r_regs [DEPTH];

  logic               r_ce;
  logic [5:0]         r_opcode;
  logic [5:0]         r_funct;
  logic [4:0]         r_shamt;
  logic [AWIDTH-1:0]  r_rs;
  logic [AWIDTH-1:0]  r_rt;
  logic [AWIDTH-1:0]  r_rd;
  logic [DWIDTH-1:0]  r_data_rs;
  logic [DWIDTH-1:0]  r_data_rt;
  logic [DWIDTH-1:0]  r_imm;
  logic [25:0]        r_jaddr;
  logic [PCWIDTH-1:0] r_pc;
  logic               r_wr_reg;
  logic [1:0]         r_class;

  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [AWIDTH-1:0]  w_rs;
  logic [AWIDTH-1:0]  w_rt;
  logic [AWIDTH-1:0]  w_rd_field;
  logic [AWIDTH-1:0]  w_dest;
  logic               w_wr_reg;
  logic [1:0]         w_class;
  logic [DWIDTH-1:0]  w_imm;
  logic [DWIDTH-1:0]  w_data_rs;
  logic [DWIDTH-1:0]  w_data_rt;
  logic               w_wb;

  assign w_op       = bus.d_i_instr[31:26];
  assign w_funct    = bus.d_i_instr[5:0];
  assign w_rs       = AWIDTH'(bus.d_i_instr[25:21]);
  assign w_rt       = AWIDTH'(bus.d_i_instr[20:16]);
  assign w_rd_field = AWIDTH'(bus.d_i_instr[15:11]);
  assign w_wb       = bus.d_i_wr_en && (bus.d_i_wr_addr != '0);

  always_comb begin
    w_class  = 2'b11;
    w_dest   = '0;
    w_wr_reg = 1'b0;
    w_imm    = DWIDTH'($signed(bus.d_i_instr[15:0]));
    case (w_op)
      6'h00: begin
        w_class  = 2'b00;
        w_dest   = w_rd_field;
        w_wr_reg = (w_funct != 6'h08);
      end
      6'h02: w_class = 2'b10;
      6'h03: begin
        w_class  = 2'b10;
        w_dest   = AWIDTH'(31);
        w_wr_reg = 1'b1;
      end
      6'h04, 6'h05, 6'h2B: w_class = 2'b01;
      6'h08, 6'h09, 6'h0A, 6'h23: begin
        w_class  = 2'b01;
        w_dest   = w_rt;
        w_wr_reg = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_class  = 2'b01;
        w_dest   = w_rt;
        w_wr_reg = 1'b1;
        w_imm    = DWIDTH'(bus.d_i_instr[15:0]);
      end
      6'h0F: begin
        w_class  = 2'b01;
        w_dest   = w_rt;
        w_wr_reg = 1'b1;
        w_imm    = DWIDTH'({bus.d_i_instr[15:0], 16'h0000});
      end
      default: ;
    endcase
    if (w_dest == '0) w_wr_reg = 1'b0;
  end

  // Same-cycle write-back wins over the stored value.
  always_comb begin
    w_data_rs = '0;
    w_data_rt = '0;
    if (w_rs != '0) w_data_rs = (w_wb && bus.d_i_wr_addr == w_rs) ? bus.d_i_wr_data : r_regs[w_rs];
    if (w_rt != '0) w_data_rt = (w_wb && bus.d_i_wr_addr == w_rt) ? bus.d_i_wr_data : r_regs[w_rt];
  end

  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[bus.d_i_wr_addr] <= bus.d_i_wr_data;
    end
  end

  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      r_ce      <= 1'b0;
      r_opcode  <= '0;
      r_funct   <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_data_rs <= '0;
      r_data_rt <= '0;
      r_imm     <= '0;
      r_jaddr   <= '0;
      r_pc      <= '0;
      r_wr_reg  <= 1'b0;
      r_class   <= '0;
    end else if (bus.d_i_flush) begin
      r_ce <= 1'b0;
    end else if (bus.d_i_stall) begin
      // Held operands track write-backs so execute never sees stale data.
      if (r_ce && w_wb && bus.d_i_wr_addr == r_rs) r_data_rs <= bus.d_i_wr_data;
      if (r_ce && w_wb && bus.d_i_wr_addr == r_rt) r_data_rt <= bus.d_i_wr_data;
    end else begin
      r_ce      <= bus.d_i_ce;
      r_opcode  <= w_op;
      r_funct   <= w_funct;
      r_shamt   <= bus.d_i_instr[10:6];
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_rd      <= w_dest;
      r_data_rs <= w_data_rs;
      r_data_rt <= w_data_rt;
      r_imm     <= w_imm;
      r_jaddr   <= bus.d_i_instr[25:0];
      r_pc      <= bus.d_i_pc;
      r_wr_reg  <= w_wr_reg;
      r_class   <= w_class;
    end
  end

  assign bus.d_o_ce      = r_ce;
  assign bus.d_o_opcode  = r_opcode;
  assign bus.d_o_funct   = r_funct;
  assign bus.d_o_shamt   = r_shamt;
  assign bus.d_o_addr_rs = r_rs;
  assign bus.d_o_addr_rt = r_rt;
  assign bus.d_o_addr_rd = r_rd;
  assign bus.d_o_data_rs = r_data_rs;
  assign bus.d_o_data_rt = r_data_rt;
  assign bus.d_o_imm     = r_imm;
  assign bus.d_o_jaddr   = r_jaddr;
  assign bus.d_o_pc      = r_pc;
  assign bus.d_o_wr_reg  = r_wr_reg;
  assign bus.d_o_class   = r_class;
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the single-cycle MIPS decoder: a registered decode pipeline stage with an integrated register file, write-back port with same-cycle bypass, stall/flush handshake, immediate extension modes and instruction classification.
- Sits between fetch and execute: consumes one instruction per cycle when enabled and presents decoded fields plus register operands to the ALU stage one cycle later.

Parameters:
- AWIDTH, 5, register address width; register file depth = 2**AWIDTH, register 0 hardwired to zero.
- DWIDTH, 32, register data width and extended-immediate width (must be >= 16).
- IWIDTH, 32, instruction width (MIPS field layout; only 32 is supported).
- PCWIDTH, 32, program-counter width carried alongside the instruction.

Ports:
- d_clk  in  1  clock, all state on rising edge.
- d_rst  in  1  asynchronous active-high reset.
- d_i_ce  in  1  input instruction valid.
- d_i_stall  in  1  downstream stall; hold the output register.
- d_i_flush  in  1  kill the instruction in the output register.
- d_i_instr  in  IWIDTH  instruction word.
- d_i_pc  in  PCWIDTH  PC of d_i_instr.
- d_i_wr_en  in  1  write-back enable.
- d_i_wr_addr  in  AWIDTH  write-back register.
- d_i_wr_data  in  DWIDTH  write-back data.
- d_o_ce  out  1  output valid.
- d_o_opcode  out  6  instr[31:26].
- d_o_funct  out  6  instr[5:0].
- d_o_shamt  out  5  instr[10:6].
- d_o_addr_rs  out  AWIDTH  source register 1.
- d_o_addr_rt  out  AWIDTH  source register 2.
- d_o_addr_rd  out  AWIDTH  destination register, resolved per class.
- d_o_data_rs  out  DWIDTH  operand for rs.
- d_o_data_rt  out  DWIDTH  operand for rt.
- d_o_imm  out  DWIDTH  extended immediate.
- d_o_jaddr  out  26  jump target field instr[25:0].
- d_o_pc  out  PCWIDTH  PC of the decoded instruction.
- d_o_wr_reg  out  1  instruction writes a register.
- d_o_class  out  2  00 R, 01 I, 10 J, 11 illegal.

Behaviour:
- Reset (async, d_rst=1): every output is 0, including d_o_ce and d_o_class=00. All register-file entries are cleared to 0.
- Latency: 1 cycle. Instruction registered at edge N appears on the outputs after edge N.
- Per-edge priority: reset > flush > stall > load.
  - Flush: d_o_ce <= 0; other outputs are don't-care but hold.
  - Stall (no flush): all outputs hold, except for the operand refresh below.
  - Load: when neither flush nor stall is asserted, d_o_ce <= d_i_ce and all fields are registered from d_i_instr and d_i_pc. When d_i_ce=0, d_o_ce <= 0.
- Register file:
  - Write occurs on the rising edge when d_i_wr_en=1 and d_i_wr_addr != 0. Writes to register 0 are ignored.
  - Reads are combinational with bypass: if d_i_wr_en=1 and d_i_wr_addr equals a read address (nonzero) in the same cycle, d_i_wr_data is captured instead of the stored value.
  - A read of register 0 always returns 0.
- Operand refresh while stalled: when d_o_ce=1 and d_i_stall=1, a write-back whose address equals d_o_addr_rs (or d_o_addr_rt), nonzero, updates d_o_data_rs (or d_o_data_rt) at the same edge. Both update if both addresses match.
- Decode table (opcode hex):
  - 00 R-type: class 00, dest = rd, wr_reg = 1, except funct 08 (JR) which gives wr_reg = 0.
  - 02 J: class 10, wr_reg = 0.
  - 03 JAL: class 10, dest = 31, wr_reg = 1.
  - 04 BEQ, 05 BNE, 2B SW: class 01, wr_reg = 0.
  - 08 ADDI, 09 ADDIU, 0A SLTI, 0C ANDI, 0D ORI, 0E XORI, 0F LUI, 23 LW: class 01, dest = rt, wr_reg = 1.
  - Any other opcode: class 11, wr_reg = 0, d_o_ce still follows the handshake.
- Immediate extension:
  - ANDI, ORI, XORI: zero-extend instr[15:0].
  - LUI: instr[15:0] << 16, low bits zero.
  - All others: sign-extend instr[15:0] to DWIDTH.
- When dest = 0, d_o_wr_reg is forced to 0.

Test Plan:
- Reset mid-operation: assert d_rst asynchronously between edges while d_o_ce=1 -> all outputs 0 immediately; regfile reads return 0 afterwards.
- Write $2=5, $3=7, then feed 0x00430820 (ADD $1,$2,$3) -> next cycle: rs=2, rt=3, rd=1, data_rs=5, data_rt=7, class=00, wr_reg=1.
- Bypass and immediates: feed 0x2041FFFC (ADDI $1,$2,-4) in the same cycle as a write of $2=0x10 -> data_rs=0x10, imm=0xFFFFFFFC, rd=1. Then 0x3441FFFC (ORI) -> imm=0x0000FFFC; 0x3C011234 (LUI) -> imm=0x12340000.
- Stall/refresh: ADD $1,$2,$3 held with d_i_stall=1 while writing $3=0x99 -> outputs hold, data_rt becomes 0x99; release stall -> next instruction loads.
- Flush/JAL/illegal: 0x0C000010 (JAL) -> class=10, rd=31, jaddr=0x10, wr_reg=1. Flush on the next edge -> d_o_ce=0. Opcode 0x3F -> class=11, wr_reg=0. Write to $0 followed by a read -> 0.
